// File: rtl/dmem_bridge.sv
// dmem_bridge: bridges a single-outstanding core data-memory port onto a Wishbone classic bus.
// Ports:
//   clk_i, rst_ni            clock (rising edge) and asynchronous active-low reset
//   mem_read_i, mem_write_i  core load/store request, sampled only while idle
//   mem_strb_i, mem_addr_i   byte lane strobes and word address (bits [1:0] dropped)
//   mem_data_i               lane-aligned store data
//   stall_o                  high while a bus cycle is outstanding
//   rvalid_o, rdata_o        one-cycle load completion pulse and its data (data held between pulses)
//   err_o                    one-cycle error pulse (bus error, timeout, or read+write conflict)
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o   Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i                                 Wishbone slave responses
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [3:0]  mem_strb_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic        stall_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    // A zero TIMEOUT still needs a legal one-bit counter even though it is never compared.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic [3:0]     sel_q, sel_d;
    logic           we_q, we_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rvalid_q, rvalid_d;
    logic           err_q, err_d;
    logic           busy;
    logic           timed_out;

    assign busy = (state_q == BUSY);

    // The current edge closes the TIMEOUT-th busy cycle.
    assign timed_out = (TIMEOUT != 0) && ((cnt_q + CW'(1)) == CW'(TIMEOUT));

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        if (!busy) begin
            if (mem_read_i || mem_write_i) begin
                state_d = BUSY;
                adr_d   = mem_addr_i & 32'hFFFF_FFFC;
                dat_d   = mem_data_i;
                sel_d   = mem_strb_i;
                we_d    = mem_write_i;
                cnt_d   = '0;
                // Conflicting read+write proceeds as a store but is flagged in the first busy cycle.
                err_d   = mem_read_i && mem_write_i;
            end
        end else if (wb_err_i || (!wb_ack_i && timed_out)) begin
            state_d  = IDLE;
            rdata_d  = '0;
            rvalid_d = !we_q;
            err_d    = 1'b1;
        end else if (wb_ack_i) begin
            state_d  = IDLE;
            rdata_d  = we_q ? rdata_q : wb_dat_i;
            rvalid_d = !we_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Bus outputs are forced to zero while idle so stale latched values never leak out.
    assign stall_o  = busy;
    assign wb_cyc_o = busy;
    assign wb_stb_o = busy;
    assign wb_we_o  = busy & we_q;
    assign wb_sel_o = busy ? sel_q : 4'h0;
    assign wb_adr_o = busy ? adr_q : 32'h0;
    assign wb_dat_o = busy ? dat_q : 32'h0;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: scoreboard-driven bench for dmem_bridge with TIMEOUT=4.
module tb_dmem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [3:0]  mem_strb_i = 4'h0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_data_i = 32'h0;
    logic        stall_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        rv;
        logic        er;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];

    dmem_bridge #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_strb_i(mem_strb_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .stall_o(stall_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Drives one request starting at a negedge, plays the slave (ack on busy cycle ack_at, 0 = never),
    // and returns observations; ends at the negedge of the cycle after completion.
    task automatic xfer(input logic rd, input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] data, input int ack_at, input logic use_err, input logic [31:0] rsp,
                        output int n_stall, output logic first_err, output logic [31:0] s_adr,
                        output logic [31:0] s_dat, output logic [3:0] s_sel, output logic s_we,
                        output logic s_cyc, output logic c_rv, output logic c_er, output logic [31:0] c_rd,
                        output logic to);
        mem_read_i = rd; mem_write_i = wr; mem_strb_i = strb; mem_addr_i = addr; mem_data_i = data;
        wb_dat_i = rsp;
        @(negedge clk_i);
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        n_stall = 0; to = 1'b0;
        first_err = err_o; s_adr = wb_adr_o; s_dat = wb_dat_o; s_sel = wb_sel_o; s_we = wb_we_o;
        s_cyc = wb_cyc_o & wb_stb_o;
        while (stall_o === 1'b1 && !to) begin
            n_stall++;
            if (n_stall > 40) to = 1'b1;
            wb_ack_i = (n_stall == ack_at);
            wb_err_i = (n_stall == ack_at) && use_err;
            @(negedge clk_i);
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
        end
        c_rv = rvalid_o; c_er = err_o; c_rd = rdata_o;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        vectors++; if (stall_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_ctl: got stall=%b cyc=%b stb=%b we=%b want 0", stall_o, wb_cyc_o, wb_stb_o, wb_we_o); end
        vectors++; if ({wb_sel_o, wb_adr_o, wb_dat_o} !== 68'h0) begin miscompares++; $display("FAIL reset_bus: got sel=%h adr=%h dat=%h want 0", wb_sel_o, wb_adr_o, wb_dat_o); end
        vectors++; if (rvalid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0) begin miscompares++; $display("FAIL reset_rsp: got rv=%b er=%b rd=%h want 0", rvalid_o, err_o, rdata_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_load();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        sbq.push_back('{rv: 1'b1, er: 1'b0, d: 32'hDEADBEEF});
        xfer(1, 0, 4'hF, 32'h0000_1003, 32'h0, 3, 0, 32'hDEADBEEF, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (to) begin miscompares++; $display("FAIL load_timeout: bench gave up waiting on stall_o"); end
        vectors++; if (a !== 32'h0000_1000) begin miscompares++; $display("FAIL load_adr: got %h want 00001000", a); end
        vectors++; if (we !== 1'b0 || cyc !== 1'b1) begin miscompares++; $display("FAIL load_ctl: got we=%b cyc=%b want 0/1", we, cyc); end
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL load_stall: got %0d want 3", n); end
        vectors++; if (rv !== e.rv || er !== e.er || rd !== e.d) begin miscompares++; $display("FAIL load_rsp: got rv=%b er=%b rd=%h want %b %b %h", rv, er, rd, e.rv, e.er, e.d); end
        @(negedge clk_i);
        vectors++; if (rvalid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_hold: got rv=%b er=%b rd=%h want 0 0 deadbeef", rvalid_o, err_o, rdata_o); end
    endtask

    task automatic test_store();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        sbq.push_back('{rv: 1'b0, er: 1'b0, d: 32'hDEADBEEF});
        xfer(0, 1, 4'b0011, 32'h0000_2000, 32'h0000_A5A5, 1, 0, 32'h1111_1111, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (we !== 1'b1 || s !== 4'h3 || d !== 32'h0000_A5A5) begin miscompares++; $display("FAIL store_bus: got we=%b sel=%h dat=%h want 1 3 0000a5a5", we, s, d); end
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL store_stall: got %0d want 1", n); end
        vectors++; if (rv !== e.rv || er !== e.er || rd !== e.d) begin miscompares++; $display("FAIL store_rsp: got rv=%b er=%b rd=%h want %b %b %h", rv, er, rd, e.rv, e.er, e.d); end
    endtask

    task automatic test_err_ack();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        sbq.push_back('{rv: 1'b1, er: 1'b1, d: 32'h0});
        xfer(1, 0, 4'hF, 32'h0000_3004, 32'h0, 2, 1, 32'h1234_5678, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL errack_stall: got %0d want 2", n); end
        vectors++; if (rv !== e.rv || er !== e.er || rd !== e.d) begin miscompares++; $display("FAIL errack_rsp: got rv=%b er=%b rd=%h want %b %b %h", rv, er, rd, e.rv, e.er, e.d); end
        @(negedge clk_i);
        vectors++; if (rvalid_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("FAIL errack_pulse: got rv=%b er=%b want 0 0", rvalid_o, err_o); end
    endtask

    task automatic test_timeout();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        sbq.push_back('{rv: 1'b1, er: 1'b1, d: 32'h0});
        xfer(1, 0, 4'hF, 32'h0000_4000, 32'h0, 0, 0, 32'hFFFF_FFFF, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL timeout_stall: got %0d want 4", n); end
        vectors++; if (rv !== e.rv || er !== e.er || rd !== e.d) begin miscompares++; $display("FAIL timeout_rsp: got rv=%b er=%b rd=%h want %b %b %h", rv, er, rd, e.rv, e.er, e.d); end
        vectors++; if (wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL timeout_cyc: got %b want 0", wb_cyc_o); end
    endtask

    task automatic test_zero_strb();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s;
        xfer(0, 1, 4'h0, 32'h0000_5008, 32'h7777_7777, 1, 0, 32'h0, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        vectors++; if (cyc !== 1'b1 || s !== 4'h0 || we !== 1'b1 || a !== 32'h0000_5008) begin miscompares++; $display("FAIL zstrb_bus: got cyc=%b sel=%h we=%b adr=%h want 1 0 1 00005008", cyc, s, we, a); end
        vectors++; if (n !== 1 || rv !== 1'b0 || er !== 1'b0) begin miscompares++; $display("FAIL zstrb_done: got stall=%0d rv=%b er=%b want 1 0 0", n, rv, er); end
    endtask

    task automatic test_both();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        sbq.push_back('{rv: 1'b0, er: 1'b0, d: 32'h0});
        xfer(1, 1, 4'hF, 32'h0000_600C, 32'hCAFE_F00D, 2, 0, 32'h0, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (we !== 1'b1 || d !== 32'hCAFE_F00D || fe !== 1'b1) begin miscompares++; $display("FAIL both_first: got we=%b dat=%h err=%b want 1 cafef00d 1", we, d, fe); end
        vectors++; if (n !== 2 || rv !== e.rv || er !== e.er) begin miscompares++; $display("FAIL both_done: got stall=%0d rv=%b er=%b want 2 %b %b", n, rv, er, e.rv, e.er); end
    endtask

    task automatic test_back_to_back();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        sbq.push_back('{rv: 1'b1, er: 1'b0, d: 32'h0000_0001});
        sbq.push_back('{rv: 1'b1, er: 1'b0, d: 32'h0000_0002});
        xfer(1, 0, 4'hF, 32'h0000_7000, 32'h0, 1, 0, 32'h0000_0001, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (stall_o !== 1'b0 || rv !== e.rv || rd !== e.d) begin miscompares++; $display("FAIL b2b_first: got stall=%b rv=%b rd=%h want 0 %b %h", stall_o, rv, rd, e.rv, e.d); end
        xfer(1, 0, 4'hF, 32'h0000_7004, 32'h0, 1, 0, 32'h0000_0002, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (a !== 32'h0000_7004 || n !== 1 || rv !== e.rv || rd !== e.d) begin miscompares++; $display("FAIL b2b_second: got adr=%h stall=%0d rv=%b rd=%h want 00007004 1 %b %h", a, n, rv, rd, e.rv, e.d); end
    endtask

    task automatic test_reset_busy();
        int n; logic fe, we, cyc, rv, er, to; logic [31:0] a, d, rd; logic [3:0] s; exp_t e;
        mem_read_i = 1'b1; mem_addr_i = 32'h0000_8000;
        @(negedge clk_i);
        mem_read_i = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (wb_cyc_o !== 1'b0 || stall_o !== 1'b0 || rvalid_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("FAIL rstbusy_abort: got cyc=%b stall=%b rv=%b er=%b want 0", wb_cyc_o, stall_o, rvalid_o, err_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        vectors++; if (rvalid_o !== 1'b0 || err_o !== 1'b0 || stall_o !== 1'b0) begin miscompares++; $display("FAIL rstbusy_quiet: got rv=%b er=%b stall=%b want 0", rvalid_o, err_o, stall_o); end
        sbq.push_back('{rv: 1'b1, er: 1'b0, d: 32'h0BAD_F00D});
        xfer(1, 0, 4'hF, 32'h0000_8000, 32'h0, 1, 0, 32'h0BAD_F00D, n, fe, a, d, s, we, cyc, rv, er, rd, to);
        e = sbq.pop_front();
        vectors++; if (n !== 1 || rv !== e.rv || er !== e.er || rd !== e.d) begin miscompares++; $display("FAIL rstbusy_next: got stall=%0d rv=%b er=%b rd=%h want 1 %b %b %h", n, rv, er, rd, e.rv, e.er, e.d); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_err_ack();
        test_timeout();
        test_zero_strb();
        test_both();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
